// File: rtl/baopoco_coeff_bank_loader.sv
// Coefficient bank loader: turns software-register commands into writes on the shadow
// bank of a double-buffered coefficient BRAM and swaps the read bank on a frame sync.
module baopoco_coeff_bank_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_in,
  input  logic              sync_in,
  output logic              bram_we,
  output logic [ADDR_W:0]   bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              rd_bank,
  output logic [31:0]       status_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [2:0]        ctrl_q, ctrl_d, ctrl_qq, ctrl_dd;
  logic [1:0]        state_q, state_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;
  logic [ADDR_W-1:0] fill_end_q, fill_end_d;
  logic              rd_bank_q, rd_bank_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       status_q, status_d;
  logic [2:0]        rise_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic              unused_s;

  assign unused_s = ^{ctrl_in[31:3], addr_in[15:ADDR_W], addr_in[31:16+ADDR_W],
                      data_in[31:DATA_W]};

  // Command decode, write sequencing and bank swap
  always_comb begin
    ctrl_d      = ctrl_in[2:0];
    ctrl_dd     = ctrl_q;
    rise_s      = ctrl_q & ~ctrl_qq;
    state_d     = state_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    fill_end_d  = fill_end_q;
    rd_bank_d   = rd_bank_q;
    addr_next_s = bram_addr_q[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
    case (state_q)
      S_IDLE: begin
        // WR > FILL > COMMIT; losing edges are simply dropped
        if (rise_s[0]) begin
          bram_we_d   = 1'b1;
          bram_addr_d = {~rd_bank_q, addr_in[ADDR_W-1:0]};
          bram_din_d  = data_in[DATA_W-1:0];
          state_d     = S_WRITE;
        end else if (rise_s[1]) begin
          bram_we_d   = 1'b1;
          bram_addr_d = {~rd_bank_q, addr_in[ADDR_W-1:0]};
          bram_din_d  = data_in[DATA_W-1:0];
          fill_end_d  = addr_in[16 +: ADDR_W];
          state_d     = S_FILL;
        end else if (rise_s[2]) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_FILL: begin
        // The address just written is the end address: fill is complete
        if (bram_addr_q[ADDR_W-1:0] == fill_end_q) begin
          state_d = S_IDLE;
        end else begin
          bram_we_d   = 1'b1;
          bram_addr_d = {~rd_bank_q, addr_next_s};
        end
      end
      S_COMMIT: begin
        if (sync_in) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = S_IDLE;
        end else begin
          state_d = S_COMMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    count_d  = count_q + {15'd0, bram_we_d};
    status_d = {count_q, 13'd0, rd_bank_q, (state_q == S_COMMIT), (state_q != S_IDLE)};
  end

  // State and output registers with synchronous reset
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ctrl_q      <= 3'd0;
      ctrl_qq     <= 3'd0;
      state_q     <= S_IDLE;
      bram_we_q   <= 1'b0;
      bram_addr_q <= {(ADDR_W+1){1'b0}};
      bram_din_q  <= {DATA_W{1'b0}};
      fill_end_q  <= {ADDR_W{1'b0}};
      rd_bank_q   <= 1'b0;
      count_q     <= 16'd0;
      status_q    <= 32'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      ctrl_qq     <= ctrl_dd;
      state_q     <= state_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      fill_end_q  <= fill_end_d;
      rd_bank_q   <= rd_bank_d;
      count_q     <= count_d;
      status_q    <= status_d;
    end
  end

  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign rd_bank    = rd_bank_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_baopoco_coeff_bank_loader.sv
// Directed self-checking bench for baopoco_coeff_bank_loader; inputs change and outputs
// are sampled 1 time unit after each rising clock edge, writes are logged on falling edges.
module tb_baopoco_coeff_bank_loader;

  logic        user_clk;
  logic        user_rst;
  logic [31:0] ctrl_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        sync_in;
  logic        bram_we;
  logic [10:0] bram_addr;
  logic [15:0] bram_din;
  logic        rd_bank;
  logic [31:0] status_out;

  int errors;
  int checks;
  int cyc;
  int nwr;
  logic [10:0] la[$];
  logic [15:0] ld[$];
  int          lc[$];

  baopoco_coeff_bank_loader #(.ADDR_W(10), .DATA_W(16)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .ctrl_in(ctrl_in), .addr_in(addr_in),
    .data_in(data_in), .sync_in(sync_in), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .rd_bank(rd_bank), .status_out(status_out)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  always @(negedge user_clk) begin
    if (bram_we === 1'b1) begin
      nwr = nwr + 1;
      if (la.size() < 2000) begin
        la.push_back(bram_addr);
        ld.push_back(bram_din);
        lc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic apply_reset();
    user_rst = 1'b1;
    ctrl_in  = 32'd0;
    sync_in  = 1'b0;
    tick(2);
    user_rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", bram_we); end
    checks++; if (bram_addr !== 11'h000) begin errors++; $display("FAIL reset_addr got=%h want=000", bram_addr); end
    checks++; if (bram_din !== 16'h0000) begin errors++; $display("FAIL reset_din got=%h want=0000", bram_din); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got=%b want=0", rd_bank); end
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL reset_status got=%h want=00000000", status_out); end
  endtask

  task automatic test_single_write();
    apply_reset();
    addr_in = 32'h0000_0005;
    data_in = 32'h0000_1234;
    clear_log();
    ctrl_in = 32'h1;
    tick(1);
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL wr_early got=%b want=0", bram_we); end
    tick(1);
    checks++; if (bram_we !== 1'b1) begin errors++; $display("FAIL wr_we got=%b want=1", bram_we); end
    checks++; if (bram_addr !== 11'h405) begin errors++; $display("FAIL wr_addr got=%h want=405", bram_addr); end
    checks++; if (bram_din !== 16'h1234) begin errors++; $display("FAIL wr_din got=%h want=1234", bram_din); end
    tick(1);
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got=%b want=0", bram_we); end
    tick(1);
    checks++; if (status_out !== 32'h0001_0000) begin errors++; $display("FAIL wr_status got=%h want=00010000", status_out); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL wr_rd_bank got=%b want=0", rd_bank); end
    checks++; if (la.size() != 1) begin errors++; $display("FAIL wr_count_log got=%0d want=1", la.size()); end
    ctrl_in = 32'h0;
  endtask

  task automatic test_fill_wrap();
    logic [10:0] exp_a [4];
    int busy_cycles;
    exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h400; exp_a[3] = 11'h401;
    apply_reset();
    addr_in = 32'h0001_03FE;
    data_in = 32'h0000_AAAA;
    clear_log();
    busy_cycles = 0;
    ctrl_in = 32'h2;
    repeat (12) begin
      tick(1);
      if (status_out[0] === 1'b1) busy_cycles++;
    end
    ctrl_in = 32'h0;
    checks++; if (la.size() != 4) begin errors++; $display("FAIL fill_len got=%0d want=4", la.size()); end
    for (int i = 0; i < 4 && i < la.size(); i++) begin
      checks++;
      if (la[i] !== exp_a[i] || ld[i] !== 16'hAAAA || lc[i] != lc[0] + i) begin
        errors++;
        $display("FAIL fill_word%0d got=%h/%h/cyc%0d want=%h/aaaa/cyc%0d", i, la[i], ld[i], lc[i], exp_a[i], lc[0] + i);
      end
    end
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL fill_busy got=%0d want=4", busy_cycles); end
    checks++; if (status_out !== 32'h0004_0000) begin errors++; $display("FAIL fill_status got=%h want=00040000", status_out); end
  endtask

  task automatic test_commit();
    apply_reset();
    ctrl_in = 32'h4;
    tick(1);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    tick(1);
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL commit_early_sync got=%b want=0", rd_bank); end
    checks++; if (status_out[1] !== 1'b1) begin errors++; $display("FAIL commit_pending got=%b want=1", status_out[1]); end
    tick(2);
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL commit_hold got=%b want=0", rd_bank); end
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL commit_swap got=%b want=1", rd_bank); end
    checks++; if (status_out[1] !== 1'b1) begin errors++; $display("FAIL commit_pending_late got=%b want=1", status_out[1]); end
    tick(1);
    checks++; if (status_out !== 32'h0000_0004) begin errors++; $display("FAIL commit_status got=%h want=00000004", status_out); end
    ctrl_in = 32'h0;
    addr_in = 32'h0000_0007;
    data_in = 32'h0000_0055;
    tick(1);
    clear_log();
    ctrl_in = 32'h1;
    tick(4);
    ctrl_in = 32'h0;
    checks++;
    if (la.size() != 1 || la[0] !== 11'h007 || ld[0] !== 16'h0055) begin
      errors++;
      $display("FAIL commit_bank0_write got=%0d writes first=%h want=1 write 007/0055", la.size(), (la.size() > 0) ? la[0] : 11'h0);
    end
  endtask

  task automatic test_simultaneous();
    logic seen_pending;
    apply_reset();
    addr_in = 32'h0000_0010;
    data_in = 32'h0000_BEEF;
    clear_log();
    seen_pending = 1'b0;
    ctrl_in = 32'h7;
    repeat (10) begin
      tick(1);
      if (status_out[1] === 1'b1) seen_pending = 1'b1;
    end
    ctrl_in = 32'h0;
    checks++;
    if (la.size() != 1 || la[0] !== 11'h410 || ld[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL simul_write got=%0d writes first=%h want=1 write 410/beef", la.size(), (la.size() > 0) ? la[0] : 11'h0);
    end
    checks++; if (seen_pending !== 1'b0) begin errors++; $display("FAIL simul_no_commit got=%b want=0", seen_pending); end
    checks++; if (status_out !== 32'h0001_0000) begin errors++; $display("FAIL simul_status got=%h want=00010000", status_out); end
  endtask

  task automatic test_wr_during_fill();
    int bad;
    apply_reset();
    addr_in = 32'h002F_0020;
    data_in = 32'h0000_0F0F;
    clear_log();
    ctrl_in = 32'h2;
    tick(4);
    ctrl_in = 32'h3;
    tick(25);
    ctrl_in = 32'h0;
    tick(3);
    bad = 0;
    for (int i = 0; i < la.size(); i++) begin
      if (ld[i] !== 16'h0F0F || la[i] !== (11'h420 + 11'(i))) bad++;
    end
    checks++; if (la.size() != 16) begin errors++; $display("FAIL drop_len got=%0d want=16", la.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_words got=%0d bad want=0", bad); end
    checks++; if (status_out !== 32'h0010_0000) begin errors++; $display("FAIL drop_status got=%h want=00100000", status_out); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    addr_in = 32'h0000_0001;
    data_in = 32'h0000_0011;
    clear_log();
    ctrl_in = 32'h1;
    tick(2);
    addr_in = 32'h0101_0100;
    data_in = 32'h0000_0022;
    ctrl_in = 32'h3;
    tick(8);
    ctrl_in = 32'h0;
    checks++; if (la.size() != 3) begin errors++; $display("FAIL b2b_len got=%0d want=3", la.size()); end
    if (la.size() == 3) begin
      checks++;
      if (la[0] !== 11'h401 || ld[0] !== 16'h0011 || la[1] !== 11'h500 || la[2] !== 11'h501 ||
          ld[1] !== 16'h0022 || ld[2] !== 16'h0022 || lc[1] != lc[0] + 2 || lc[2] != lc[0] + 3) begin
        errors++;
        $display("FAIL b2b_words got=%h/%h@%0d %h/%h@%0d %h/%h@%0d want=401/0011 500/0022@+2 501/0022@+3",
                 la[0], ld[0], lc[0], la[1], ld[1], lc[1], la[2], ld[2], lc[2]);
      end
    end
    checks++; if (status_out !== 32'h0003_0000) begin errors++; $display("FAIL b2b_status got=%h want=00030000", status_out); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    addr_in = 32'h0063_0000;
    data_in = 32'h0000_7777;
    ctrl_in = 32'h2;
    tick(3);
    user_rst = 1'b1;
    ctrl_in  = 32'h0;
    tick(1);
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b want=0", bram_we); end
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL rstmid_status got=%h want=00000000", status_out); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL rstmid_rd_bank got=%b want=0", rd_bank); end
    user_rst = 1'b0;
    clear_log();
    tick(10);
    checks++; if (la.size() != 0) begin errors++; $display("FAIL rstmid_no_writes got=%0d want=0", la.size()); end
    ctrl_in = 32'h4;
    tick(3);
    user_rst = 1'b1;
    ctrl_in  = 32'h0;
    tick(1);
    user_rst = 1'b0;
    sync_in  = 1'b1;
    tick(1);
    sync_in  = 1'b0;
    tick(2);
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL rstcommit_rd_bank got=%b want=0", rd_bank); end
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL rstcommit_status got=%h want=00000000", status_out); end
  endtask

  task automatic test_count_wrap();
    int n0;
    apply_reset();
    n0 = nwr;
    for (int f = 0; f < 64; f++) begin
      addr_in = 32'h03FF_0000;
      data_in = 32'(f);
      ctrl_in = 32'h2;
      tick(1);
      ctrl_in = 32'h0;
      tick(1030);
    end
    addr_in = 32'h0000_0000;
    ctrl_in = 32'h1;
    tick(1);
    ctrl_in = 32'h0;
    tick(4);
    checks++; if (nwr - n0 != 65537) begin errors++; $display("FAIL wrap_writes got=%0d want=65537", nwr - n0); end
    checks++; if (status_out[31:16] !== 16'h0001) begin errors++; $display("FAIL wrap_count got=%h want=0001", status_out[31:16]); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    nwr      = 0;
    user_rst = 1'b1;
    ctrl_in  = 32'h0;
    addr_in  = 32'h0;
    data_in  = 32'h0;
    sync_in  = 1'b0;
    test_reset();
    test_single_write();
    test_fill_wrap();
    test_commit();
    test_simultaneous();
    test_wr_during_fill();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
